pattern_scan_ctrl: RTL and testbench

PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

---
 rtl/pattern_scan_ctrl.sv | 157 +++++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: serialises a latched word MSB first into an external
// serial matcher, clears the matcher before each scan, and counts the
// detections the matcher reports one cycle after each driven bit.
module pattern_scan_ctrl #(
   parameter int W = 16
) (
   input  logic         CLK,
   input  logic         reset,
   input  logic         start,
   input  logic         abort,
   input  logic [W-1:0] data_in,
   input  logic [4:0]   len,
   input  logic         match_b,
   output logic         match_a,
   output logic         match_rst,
   output logic         busy,
   output logic         done,
   output logic [4:0]   match_count,
   output logic         found,
   output logic [3:0]   first_pos
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_SHIFT = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [4:0] LP_W = 5'(W);

   state_t       r_state;
   logic [W-1:0] r_sh;        // remaining bits, next bit to send at MSB
   logic [4:0]   r_len;       // clamped scan length
   logic [3:0]   r_idx;       // index of the bit currently on match_a
   logic         r_det_v;     // previous cycle drove a scan bit
   logic [3:0]   r_det_idx;   // index of the bit driven in the previous cycle
   logic         r_match_a;
   logic         r_match_rst;
   logic         r_busy;
   logic         r_done;
   logic [4:0]   r_count;
   logic         r_found;
   logic [3:0]   r_first_pos;
   logic [4:0]   w_len_clamped;

   assign w_len_clamped = (len > LP_W) ? LP_W : len;

   assign match_a     = r_match_a;
   assign match_rst   = r_match_rst;
   assign busy        = r_busy;
   assign done        = r_done;
   assign match_count = r_count;
   assign found       = r_found;
   assign first_pos   = r_first_pos;

   // Scan FSM with registered outputs; abort overrides the normal transition.
   always_ff @(posedge CLK) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_sh        <= '0;
         r_len       <= 5'd0;
         r_idx       <= 4'd0;
         r_det_v     <= 1'b0;
         r_det_idx   <= 4'd0;
         r_match_a   <= 1'b0;
         r_match_rst <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_count     <= 5'd0;
         r_found     <= 1'b0;
         r_first_pos <= 4'd0;
      end else begin
         // Pulse-style outputs fall back to zero unless a state drives them.
         r_match_a   <= 1'b0;
         r_match_rst <= 1'b0;
         r_done      <= 1'b0;
         r_det_v     <= 1'b0;

         // Matcher answer for the bit driven in the previous SHIFT cycle.
         if (r_det_v && match_b) begin
            if (r_count < LP_W) begin
               r_count <= r_count + 5'd1;
            end
            if (!r_found) begin
               r_found     <= 1'b1;
               r_first_pos <= r_det_idx;
            end
         end

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_count     <= 5'd0;
                  r_found     <= 1'b0;
                  r_first_pos <= 4'd0;
                  r_idx       <= 4'd0;
                  if (len == 5'd0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_sh        <= data_in;
                     r_len       <= w_len_clamped;
                     r_state     <= S_CLEAR;
                     r_match_rst <= 1'b1;
                     r_busy      <= 1'b1;
                  end
               end
            end
            S_CLEAR: begin
               r_state   <= S_SHIFT;
               r_idx     <= 4'd0;
               r_match_a <= r_sh[W-1];
               r_sh      <= r_sh << 1;
            end
            S_SHIFT: begin
               r_det_v   <= 1'b1;
               r_det_idx <= r_idx;
               if ({1'b0, r_idx} == (r_len - 5'd1)) begin
                  r_state <= S_DRAIN;
               end else begin
                  r_idx     <= r_idx + 4'd1;
                  r_match_a <= r_sh[W-1];
                  r_sh      <= r_sh << 1;
               end
            end
            S_DRAIN: begin
               r_state <= S_DONE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase

         // Abort cancels an active scan and clears the matcher on the way out.
         if (abort && r_busy) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_match_a   <= 1'b0;
            r_match_rst <= 1'b1;
            r_det_v     <= 1'b0;
            r_count     <= 5'd0;
            r_found     <= 1'b0;
            r_first_pos <= 4'd0;
         end
      end
   end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed self-checking bench for pattern_scan_ctrl. Inputs are changed on
// the falling edge (meaning "during this cycle") and outputs are checked on
// the falling edge after the rising edge that produced them.
module tb_pattern_scan_ctrl;

   logic        CLK = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic [15:0] data_in;
   logic [4:0]  len;
   logic        match_b;
   logic        match_a;
   logic        match_rst;
   logic        busy;
   logic        done;
   logic [4:0]  match_count;
   logic        found;
   logic [3:0]  first_pos;

   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] pat;

   pattern_scan_ctrl #(.W(16)) dut (
      .CLK         (CLK),
      .reset       (reset),
      .start       (start),
      .abort       (abort),
      .data_in     (data_in),
      .len         (len),
      .match_b     (match_b),
      .match_a     (match_a),
      .match_rst   (match_rst),
      .busy        (busy),
      .done        (done),
      .match_count (match_count),
      .found       (found),
      .first_pos   (first_pos)
   );

   always #5 CLK = ~CLK;

   task automatic cyc();
      @(negedge CLK);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic a, input logic r, input logic b, input logic d);
      chk({tag, ".match_a"},   32'(match_a),   32'(a));
      chk({tag, ".match_rst"}, 32'(match_rst), 32'(r));
      chk({tag, ".busy"},      32'(busy),      32'(b));
      chk({tag, ".done"},      32'(done),      32'(d));
   endtask

   task automatic chk_res(input string tag, input logic [4:0] c, input logic f, input logic [3:0] p);
      chk({tag, ".count"},     32'(match_count), 32'(c));
      chk({tag, ".found"},     32'(found),       32'(f));
      chk({tag, ".first_pos"}, 32'(first_pos),   32'(p));
   endtask

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      abort   = 1'b0;
      data_in = 16'h0000;
      len     = 5'd0;
      match_b = 1'b0;

      // Reset held for two rising edges.
      cyc();
      cyc();
      chk_ctl("rst", 1'b0, 1'b0, 1'b0, 1'b0);
      chk_res("rst", 5'd0, 1'b0, 4'd0);

      // Scan A: start in the first post-reset cycle, matcher silent.
      reset   = 1'b0;
      start   = 1'b1;
      data_in = 16'hA000;
      len     = 5'd4;
      cyc(); start = 1'b0;                       // T+1
      chk_ctl("A.t1", 1'b0, 1'b1, 1'b1, 1'b0);
      pat = 16'hA000;
      for (int k = 2; k <= 5; k++) begin
         cyc();
         chk_ctl("A.shift", pat[17-k], 1'b0, 1'b1, 1'b0);
      end
      cyc();                                     // T+6 drain
      chk_ctl("A.t6", 1'b0, 1'b0, 1'b1, 1'b0);
      cyc();                                     // T+7 done
      chk_ctl("A.t7", 1'b0, 1'b0, 1'b0, 1'b1);
      chk_res("A.t7", 5'd0, 1'b0, 4'd0);
      cyc();                                     // T+8 idle
      chk("A.t8.done", 32'(done), 32'd0);

      // Scan B: same word, matcher reports at T+5 and T+6 (bits 2 and 3).
      start = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         cyc();
         start   = 1'b0;
         match_b = (k == 5 || k == 6);
         if (k == 7) begin
            chk_ctl("B.t7", 1'b0, 1'b0, 1'b0, 1'b1);
            chk_res("B.t7", 5'd2, 1'b1, 4'd2);
         end
      end
      chk("B.t8.done", 32'(done), 32'd0);
      chk_res("B.hold", 5'd2, 1'b1, 4'd2);

      // Scan C: len=0 finishes immediately and clears the old results.
      len   = 5'd0;
      start = 1'b1;
      cyc(); start = 1'b0;
      chk_ctl("C.t1", 1'b0, 1'b0, 1'b0, 1'b1);
      chk_res("C.t1", 5'd0, 1'b0, 4'd0);
      cyc();
      chk_ctl("C.t2", 1'b0, 1'b0, 1'b0, 1'b0);

      // Scan D: full 16-bit scan, matcher reports every cycle.
      pat     = 16'h1234;
      data_in = pat;
      len     = 5'd16;
      match_b = 1'b1;
      start   = 1'b1;
      for (int k = 1; k <= 18; k++) begin
         cyc();
         start = 1'b0;
         chk("D.busy", 32'(busy), 32'd1);
         chk("D.done", 32'(done), 32'd0);
         if (k >= 2 && k <= 17) begin
            chk("D.match_a", 32'(match_a), 32'(pat[17-k]));
         end
      end
      cyc();                                     // T+19
      chk_ctl("D.t19", 1'b0, 1'b0, 1'b0, 1'b1);
      chk_res("D.t19", 5'd16, 1'b1, 4'd0);
      match_b = 1'b0;
      cyc();

      // Scan E: len=8, start at T+3 ignored, abort at T+4.
      data_in = 16'hFF00;
      len     = 5'd8;
      match_b = 1'b1;
      start   = 1'b1;
      cyc(); start = 1'b0;                       // T+1
      cyc();                                     // T+2
      cyc(); start = 1'b1;                       // T+3
      cyc(); start = 1'b0; abort = 1'b1;         // T+4
      chk_res("E.t4", 5'd1, 1'b1, 4'd0);
      cyc(); abort = 1'b0; match_b = 1'b0;       // T+5
      chk_ctl("E.t5", 1'b0, 1'b1, 1'b0, 1'b0);
      chk_res("E.t5", 5'd0, 1'b0, 4'd0);
      for (int k = 6; k <= 12; k++) begin
         cyc();
         chk("E.busy", 32'(busy), 32'd0);
         chk("E.done", 32'(done), 32'd0);
      end

      // Scan F: reset at T+3 of a len=8 scan discards it.
      data_in = 16'hFFFF;
      match_b = 1'b1;
      start   = 1'b1;
      cyc(); start = 1'b0;                       // T+1
      cyc();                                     // T+2
      cyc(); reset = 1'b1;                       // T+3
      cyc(); reset = 1'b0; match_b = 1'b0;       // T+4
      chk_ctl("F.t4", 1'b0, 1'b0, 1'b0, 1'b0);
      chk_res("F.t4", 5'd0, 1'b0, 4'd0);
      for (int k = 5; k <= 12; k++) begin
         cyc();
         chk("F.done", 32'(done), 32'd0);
      end

      // Scan G: new scan after reset, len=3, single report at T+4 (bit 1).
      data_in = 16'hE000;
      len     = 5'd3;
      start   = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         cyc();
         start   = 1'b0;
         match_b = (k == 4);
      end
      chk_ctl("G.t6", 1'b0, 1'b0, 1'b0, 1'b1);
      chk_res("G.t6", 5'd1, 1'b1, 4'd1);
      cyc();

      // Scan H: len above W is clamped to 16, done at T+19.
      data_in = 16'h0000;
      len     = 5'd20;
      start   = 1'b1;
      for (int k = 1; k <= 18; k++) begin
         cyc();
         start = 1'b0;
      end
      chk_ctl("H.t18", 1'b0, 1'b0, 1'b1, 1'b0);
      cyc();
      chk_ctl("H.t19", 1'b0, 1'b0, 1'b0, 1'b1);
      chk_res("H.t19", 5'd0, 1'b0, 4'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
